// File: rtl/divisor_serial_pkg.sv
// Shared definitions for the serial restoring divider.
// Contents: FSM state encoding and the default operand width.
package divisor_serial_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divisor_serial_if.sv
// Handshake/data bundle between a controller and the serial divider.
// Signals:
//   start, a, b                         : request and operands (controller -> divider)
//   busy, done, quociente, resto, div_zero : status and results (divider -> controller)
interface divisor_serial_if
  import divisor_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quociente;
  logic [WIDTH-1:0] resto;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  busy, done, quociente, resto, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quociente, resto, div_zero
  );

endinterface

// File: rtl/divisor_serial_sub1bit.sv
// 1-bit full subtractor cell, the borrow-based mirror of a full adder.
// Ports:
//   a, b  : minuend and subtrahend bits
//   b_in  : borrow in from the less significant cell
//   out   : difference bit
//   b_out : borrow out to the more significant cell
module sub1bit (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic out,
  output logic b_out
);

  assign out   = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~a & b_in) | (b & b_in);

endmodule

// File: rtl/divisor_serial.sv
// Multi-cycle unsigned restoring divider: quociente = a / b, resto = a % b,
// one quotient bit per clock. Division by zero completes in one edge with
// quociente = all ones, resto = a and div_zero set.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (aborts any operation in flight)
//   bus : divisor_serial_if slave modport (start/a/b in; busy/done/results out)
module divisor_serial
  import divisor_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  divisor_serial_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               dz_q, dz_d;

  // Subtractor chain operands: T = {R, next dividend bit}, minus zero-extended b.
  logic [WIDTH:0]     t_s;
  logic [WIDTH:0]     sub_b_s;
  logic [WIDTH:0]     d_s;
  logic [WIDTH+1:0]   brw_s;
  logic               take_d_s;

  assign t_s      = {r_q, q_q[WIDTH-1]};
  assign sub_b_s  = {1'b0, b_q};
  assign brw_s[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
      sub1bit u_sub (
        .a     (t_s[gi]),
        .b     (sub_b_s[gi]),
        .b_in  (brw_s[gi]),
        .out   (d_s[gi]),
        .b_out (brw_s[gi+1])
      );
    end
  endgenerate

  // Since T < 2*b, a borrow-free difference always fits in WIDTH bits;
  // qualifying on d_s[WIDTH] as well guarantees R can never wrap.
  assign take_d_s = ~brw_s[WIDTH+1] & ~d_s[WIDTH];

  // Next-state, datapath and output-register logic for the divider FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quo_d   = quo_q;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE, so ops run back to back.
        if (bus.start) begin
          b_d  = bus.b;
          dz_d = 1'b0;
          if (bus.b != '0) begin
            state_d = CALC;
            cnt_d   = CNT_W'(WIDTH);
            r_d     = '0;
            q_d     = bus.a;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            quo_d   = '1;
            res_d   = bus.a;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (take_d_s) begin
          r_d = d_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = t_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          quo_d   = q_d;
          res_d   = r_d;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quociente = quo_q;
  assign bus.resto     = res_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_divisor_serial.sv
// Self-checking bench for divisor_serial (WIDTH=4): directed cases, mid-op
// start toggling, back-to-back start, reset abort and an exhaustive sweep.
module tb_divisor_serial;
  import divisor_serial_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  divisor_serial_if #(.WIDTH(W)) bus ();

  divisor_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive a request (caller is at a negedge) and optionally record its expected result.
  task automatic drive_start(input int av, input int bv, input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = av[W-1:0];
    bus.b     = bv[W-1:0];
    if (push) begin
      e.a = av[W-1:0];
      e.b = bv[W-1:0];
      if (bv == 0) begin
        e.q  = {W{1'b1}};
        e.r  = av[W-1:0];
        e.dz = 1'b1;
      end else begin
        e.q  = W'(av / bv);
        e.r  = W'(av % bv);
        e.dz = 1'b0;
      end
      sb.push_back(e);
    end
  endtask

  // Pop the oldest expected result and compare against the DUT outputs now.
  task automatic compare_result(output exp_t e);
    int qv, rv;
    check("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e = '0;
    end
    check("quociente", bus.quociente, e.q);
    check("resto", bus.resto, e.r);
    check("div_zero", bus.div_zero, e.dz);
    if (e.dz == 1'b0) begin
      qv = int'(bus.quociente);
      rv = int'(bus.resto);
      check("invariant", qv * int'(e.b) + rv, int'(e.a));
      check("resto_lt_b", (rv < int'(e.b)) ? 32'd1 : 32'd0, 32'd1);
    end
  endtask

  // Wait (bounded) for done; start is dropped after the first edge.
  task automatic wait_done(input int exp_edges, input bit hold);
    int   edges;
    int   busy_n;
    bit   seen;
    exp_t e;
    edges  = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) bus.start = 1'b0;
      check("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    check("latency_edges", edges, exp_edges);
    check("busy_cycles", busy_n, exp_edges - 1);
    compare_result(e);
    if (hold) begin
      @(posedge clk);
      @(negedge clk);
      check("done_one_pulse", {31'd0, bus.done}, 32'd0);
      check("q_held", bus.quociente, e.q);
      check("r_held", bus.resto, e.r);
    end
  endtask

  initial begin
    exp_t e;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.quociente, 0);
    check("rst_r", bus.resto, 0);
    check("rst_dz", bus.div_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    drive_start(9, 2, 1'b1);  wait_done(W + 1, 1'b1);
    drive_start(15, 1, 1'b1); wait_done(W + 1, 1'b1);
    drive_start(3, 7, 1'b1);  wait_done(W + 1, 1'b1);
    drive_start(7, 0, 1'b1);  wait_done(1, 1'b1);
    drive_start(0, 5, 1'b1);  wait_done(W + 1, 1'b1);
    drive_start(6, 6, 1'b1);  wait_done(W + 1, 1'b1);

    // Start/operand activity during CALC is ignored; new start in DONE cycle is taken
    drive_start(9, 2, 1'b1);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("toggle_busy", bus.busy, 1);
      bus.start = k[0];
      bus.a     = 4'd1;
      bus.b     = 4'd1;
    end
    @(posedge clk);
    @(negedge clk);
    check("toggle_done", bus.done, 1);
    compare_result(e);
    drive_start(12, 5, 1'b1);
    wait_done(W + 1, 1'b1);

    // Reset during CALC aborts without a done pulse
    drive_start(14, 3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy0", bus.busy, 0);
    check("abort_done0", bus.done, 0);
    check("abort_q0", bus.quociente, 0);
    check("abort_r0", bus.resto, 0);
    check("abort_dz0", bus.div_zero, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
      check("abort_idle", bus.busy, 0);
    end
    drive_start(14, 3, 1'b1);
    wait_done(W + 1, 1'b1);

    // Exhaustive sweep, chained back to back (next start issued in the DONE cycle)
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        drive_start(av, bv, 1'b1);
        wait_done((bv == 0) ? 1 : W + 1, 1'b0);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
